ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Execute-stage multiply/divide unit for the RV32M extension; sits directly downstream of the ID/EX pipeline register and consumes its `mul_div_op`, `rdata1` and `rdata2` outputs. Runs multi-cycle operations with a small FSM and holds the front of the pipeline through `stall_out` until the result is ready. The result goes to the EX/MEM result mux alongside the ALU result.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mul_div_op_in`  in  4  op code from ID/EX: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; 4'b1111 = no op; 8–14 are reserved and treated as no op.
- `rs1_in`  in  32  operand A (dividend/multiplicand), from `rdata1_out` after forwarding.
- `rs2_in`  in  32  operand B (divisor/multiplier), from `rdata2_out` after forwarding.
- `flush_in`  in  1  abort the in-flight op (branch mispredict/trap).
- `result_out`  out  32  registered result; holds its value until the next completion.
- `done_out`  out  1  one-cycle pulse; `result_out` is valid in that cycle.
- `stall_out`  out  1  freeze PC, IF/ID and ID/EX while the unit is busy.

## Operation
- States:
  - IDLE: on a valid op (0–7) with `flush_in` low, capture operands and op, then go to BUSY, or to DONE for single-cycle cases.
  - BUSY: iterate; a 6-bit counter runs 0..31, and after the 32nd iteration the unit goes to DONE.
  - DONE: `done_out`=1 and `result_out` is valid; inputs are ignored; go to IDLE next cycle.
- `stall_out` is combinational: (IDLE and valid op and !`flush_in`) or BUSY. It is 0 in DONE, so ID/EX advances in the DONE cycle, and the op still present in ID/EX is not restarted.
- Signed handling: take operand magnitudes at capture, work on unsigned values, and fix signs at the end.
  - MULH: signed × signed. MULHSU: signed rs1 × unsigned rs2. MULHU: unsigned × unsigned.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Division: radix-2 restoring, one quotient bit per cycle.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Single-cycle special cases (IDLE → DONE):
  - Divisor 0: DIV/DIVU quotient = 32'hFFFF_FFFF; REM/REMU = rs1.
  - Signed overflow (rs1 = 32'h8000_0000, rs2 = 32'hFFFF_FFFF): DIV = 32'h8000_0000, REM = 0.
- `flush_in` in BUSY or DONE: go to IDLE next cycle, no `done_out` pulse, `result_out` unchanged. `flush_in` in IDLE blocks the start.
- Reset (including mid-operation): state IDLE, counter 0, `result_out`=0, `done_out`=0; `stall_out`=0 while `reset` is high.

## Timing
- Op sampled at edge T (IDLE): iterative ops give `done_out` in cycle T+33, with `stall_out` high in cycles T..T+32.
- Special-case divide, and fast multiply (see Configuration): `done_out` in cycle T+1, `stall_out` high in cycle T only.
- The earliest back-to-back op is sampled at T+34 (iterative) or T+2 (single-cycle).

## Configuration
- Macro: `MULDIV_FAST_MUL_EN`.
- Defined: MUL/MULH/MULHSU/MULHU use a single 33×33 signed multiply with the product registered, so latency is 1 (IDLE → DONE).
- Undefined: multiply is iterative shift-add, one multiplier bit per cycle, 32 cycles via BUSY, the same latency as divide.
- Divide is always iterative.

## Structure
- Shared package `riscv_muldiv_pkg` holds:
  - an op enum (MD_MUL..MD_REMU) and `MD_NOP` = 4'hF;
  - the FSM state enum (IDLE, BUSY, DONE);
  - the constants `DIV_BY_ZERO_Q` = 32'hFFFF_FFFF and `INT_MIN` = 32'h8000_0000.
  - ID_EX and the decoder reuse these.
- Sub-module `muldiv_div_iter` implements the restoring-divider datapath: remainder/quotient shift registers plus the subtract/compare for one step per enable. The FSM, counter, sign fix-up and multiply stay in the top level.

## Test plan
- DIV rs1=-20 (32'hFFFF_FFEC), rs2=3 → `result_out`=32'hFFFF_FFFA (-6) at T+33; REM on the same operands → 32'hFFFF_FFFE (-2); `stall_out` high for exactly 33 cycles.
- DIVU rs1=7, rs2=0 → 32'hFFFF_FFFF at T+1; REMU on the same operands → 7 at T+1.
- DIV rs1=32'h8000_0000, rs2=32'hFFFF_FFFF → 32'h8000_0000 at T+1; REM on the same operands → 0.
- MULH rs1=32'h8000_0000, rs2=32'h8000_0000 → 32'h4000_0000; MULHU rs1=rs2=32'hFFFF_FFFF → 32'hFFFF_FFFE; MUL on the same operands → 1. Run with and without `MULDIV_FAST_MUL_EN` (latency T+1 vs T+33).
- Start DIVU 100/7, assert `flush_in` at T+10 → IDLE at T+11, no `done_out`, `result_out` unchanged; a following op 4'hF gives no stall. Repeat with `reset` at T+10 → all outputs 0.
- Hold DIV 9/2 in ID/EX through the DONE cycle, then present 4'hF → exactly one `done_out` pulse with result 4, and no restart.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: op codes, FSM states and result constants.
// Also used by the ID/EX stage and the decoder.
package riscv_muldiv_pkg;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7,
        MD_NOP    = 4'hF
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // Codes 8..14 are reserved and behave like MD_NOP.
    function automatic logic is_valid_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring divider datapath: one quotient bit per enabled cycle on unsigned magnitudes.
// quo_nxt/rem_nxt expose the current step so the caller can register the final result.
module muldiv_div_iter (
    input  logic        clk,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_nxt,
    output logic [31:0] rem_nxt
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] div_q;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    always_comb begin
        shifted = {rem_q, quo_q[31]};
        fits    = (shifted >= {1'b0, div_q});
        diff    = shifted - {1'b0, div_q};
        rem_nxt = fits ? diff[31:0] : shifted[31:0];
        quo_nxt = {quo_q[30:0], fits};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
        end else if (en) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit. Define MULDIV_FAST_MUL_EN for a
// single-cycle 33x33 multiply; otherwise multiply is iterative shift-add like divide.
//
// state | meaning
// IDLE  | waiting for a valid op; captures operands, magnitudes and result sign
// BUSY  | one multiply or divide step per cycle, 32 steps
// DONE  | result_out valid and done_out pulses; inputs ignored
module ex_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      mul_div_op_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic            flush_in,
    output logic [XLEN-1:0] result_out,
    output logic            done_out,
    output logic            stall_out
);

    md_state_e   state;
    logic [5:0]  cnt;
    logic [3:0]  op_q;
    logic        neg_q;

    logic        start, is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic        div_zero, div_ovf, single, res_neg, div_en;
    logic [31:0] a_mag, b_mag, single_res, iter_res, div_raw, mul_res;
    logic [31:0] quo_nxt, rem_nxt;

    always_comb begin
        start    = (state == IDLE) && is_valid_op(mul_div_op_in) && !flush_in;
        is_div   = mul_div_op_in[2];
        is_rem   = mul_div_op_in[2] & mul_div_op_in[1];
        a_signed = (mul_div_op_in == MD_MULH) || (mul_div_op_in == MD_MULHSU) ||
                   (mul_div_op_in == MD_DIV)  || (mul_div_op_in == MD_REM);
        b_signed = (mul_div_op_in == MD_MULH) || (mul_div_op_in == MD_DIV) ||
                   (mul_div_op_in == MD_REM);
        a_neg    = a_signed & rs1_in[31];
        b_neg    = b_signed & rs2_in[31];
        a_mag    = a_neg ? -rs1_in : rs1_in;
        b_mag    = b_neg ? -rs2_in : rs2_in;
        // Remainder follows the dividend; quotient and products follow the XOR.
        res_neg  = is_rem ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (rs2_in == '0);
        div_ovf  = ((mul_div_op_in == MD_DIV) || (mul_div_op_in == MD_REM)) &&
                   (rs1_in == INT_MIN) && (rs2_in == '1);
        div_en   = (state == BUSY) && op_q[2];
        div_raw  = op_q[1] ? rem_nxt : quo_nxt;
    end

    muldiv_div_iter u_div (
        .clk      (clk),
        .load     (start),
        .en       (div_en),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fa, fb;
    logic signed [63:0] fp;
    logic [31:0]        fast_res;

    always_comb begin
        fa       = {a_signed & rs1_in[31], rs1_in};
        fb       = {b_signed & rs2_in[31], rs2_in};
        fp       = 64'(fa * fb);
        fast_res = (mul_div_op_in == MD_MUL) ? fp[31:0] : fp[63:32];
        single   = is_div ? (div_zero | div_ovf) : 1'b1;
        mul_res  = '0;
    end
`else
    logic [31:0] mcand_q, p_hi_q, p_lo_q;
    logic [32:0] mul_sum;
    logic [63:0] prod_fix;
    logic [31:0] fast_res;

    always_comb begin
        mul_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod_fix = {mul_sum, p_lo_q[31:1]};
        if (neg_q)
            prod_fix = -prod_fix;
        mul_res  = (op_q == MD_MUL) ? prod_fix[31:0] : prod_fix[63:32];
        single   = is_div && (div_zero | div_ovf);
        fast_res = '0;
    end

    // Partial product lives in p_hi_q while the multiplier shifts out of p_lo_q.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand_q <= a_mag;
            p_hi_q  <= '0;
            p_lo_q  <= b_mag;
        end else if ((state == BUSY) && !op_q[2]) begin
            p_hi_q <= mul_sum[32:1];
            p_lo_q <= {mul_sum[0], p_lo_q[31:1]};
        end
    end
`endif

    always_comb begin
        if (div_zero)
            single_res = is_rem ? rs1_in : DIV_BY_ZERO_Q;
        else if (div_ovf)
            single_res = is_rem ? 32'd0 : INT_MIN;
        else
            single_res = fast_res;
        iter_res = op_q[2] ? (neg_q ? -div_raw : div_raw) : mul_res;
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_q  <= mul_div_op_in;
            neg_q <= res_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            result_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (single) begin
                            result_out <= single_res;
                            state      <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_in) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            result_out <= iter_res;
                            state      <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_out = !reset && (start || (state == BUSY));
    assign done_out  = !reset && (state == DONE) && !flush_in;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: behavioural timing/result model plus directed cases.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mul_div_op_in = 4'hF;
    logic [31:0] rs1_in = '0;
    logic [31:0] rs2_in = '0;
    logic        flush_in = 1'b0;
    logic [31:0] result_out;
    logic        done_out;
    logic        stall_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .mul_div_op_in (mul_div_op_in),
        .rs1_in        (rs1_in),
        .rs2_in        (rs2_in),
        .flush_in      (flush_in),
        .result_out    (result_out),
        .done_out      (done_out),
        .stall_out     (stall_out)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 0;
        case (op)
            4'd0: begin p = sa * sb; return p[31:0]; end
            4'd1: begin p = sa * sb; return p[63:32]; end
            4'd2: begin p = sa * ub; return p[63:32]; end
            4'd3: begin p = ua * ub; return p[63:32]; end
            4'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sa / sb;
            end
            4'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                r = ua / ub;
            end
            4'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = sa % sb;
            end
            4'd7: begin
                if (b == 0) return a;
                r = ua % ub;
            end
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic bit is_single(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op < 4'd4) return (MUL_STALL == 1);
        if (b == 0) return 1;
        return ((op == 4'd4 || op == 4'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Behavioural model: remaining busy cycles, a done flag and the held result.
    int          m_left = 0;
    bit          m_done = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_done = 0; m_result = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            if (flush_in) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_result = m_pend;
                end
            end
        end else if (mul_div_op_in <= 4'd7 && !flush_in) begin
            m_pend = ref_result(mul_div_op_in, rs1_in, rs2_in);
            if (is_single(mul_div_op_in, rs1_in, rs2_in)) begin
                m_done = 1; m_result = m_pend;
            end else begin
                m_left = 32;
            end
        end
    end

    logic exp_done, exp_stall;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_done  = m_done && !flush_in && !reset;
            exp_stall = !reset && ((m_left > 0) ||
                        (m_left == 0 && !m_done && mul_div_op_in <= 4'd7 && !flush_in));
            check("model_done", {31'd0, done_out}, {31'd0, exp_done});
            check("model_stall", {31'd0, stall_out}, {31'd0, exp_stall});
            check("model_result", result_out, m_result);
        end
    end

    // Presents an op as ID/EX would: held while stall_out is high, advanced after.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int dones, output logic [31:0] res);
        bit ended;
        mul_div_op_in = op; rs1_in = a; rs2_in = b;
        stalls = 0; dones = 0; res = result_out; ended = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_out) begin dones++; res = result_out; end
            if (!stall_out) begin ended = 1; break; end
            stalls++;
        end
        if (!ended) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    int          st, dn, extra;
    logic [31:0] rs, prev;

    initial begin
        @(posedge clk); #2;
        chk_en = 1;
        @(negedge clk);
        check("reset_result", result_out, 32'd0);
        check("reset_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #2;
        reset = 0;

        check("pin_div", ref_result(4'd4, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFA);
        check("pin_rem", ref_result(4'd6, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
        check("pin_mulh", ref_result(4'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("pin_mulhu", ref_result(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_mulhsu", ref_result(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

        send(4'd4, 32'hFFFF_FFEC, 32'd3, st, dn, rs);
        check("div_neg_res", rs, 32'hFFFF_FFFA);
        check("div_neg_stall", st, 33);
        check("div_neg_dones", dn, 1);
        send(4'd6, 32'hFFFF_FFEC, 32'd3, st, dn, rs);
        check("rem_neg_res", rs, 32'hFFFF_FFFE);
        send(4'd5, 32'd7, 32'd0, st, dn, rs);
        check("divu_zero_res", rs, 32'hFFFF_FFFF);
        check("divu_zero_stall", st, 1);
        send(4'd7, 32'd7, 32'd0, st, dn, rs);
        check("remu_zero_res", rs, 32'd7);
        check("remu_zero_stall", st, 1);
        send(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, st, dn, rs);
        check("div_ovf_res", rs, 32'h8000_0000);
        check("div_ovf_stall", st, 1);
        send(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, st, dn, rs);
        check("rem_ovf_res", rs, 32'd0);
        send(4'd1, 32'h8000_0000, 32'h8000_0000, st, dn, rs);
        check("mulh_res", rs, 32'h4000_0000);
        check("mulh_stall", st, MUL_STALL);
        send(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, dn, rs);
        check("mulhu_res", rs, 32'hFFFF_FFFE);
        send(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, dn, rs);
        check("mul_res", rs, 32'd1);
        check("mul_stall", st, MUL_STALL);

        // Op held through DONE, then a bubble: exactly one completion, no restart.
        send(4'd4, 32'd9, 32'd2, st, dn, rs);
        check("hold_res", rs, 32'd4);
        check("hold_dones", dn, 1);
        mul_div_op_in = 4'hF;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_out || stall_out) extra++;
        end
        check("hold_no_restart", extra, 0);

        // Flush mid-divide.
        @(posedge clk); #2;
        prev = result_out;
        mul_div_op_in = 4'd5; rs1_in = 32'd100; rs2_in = 32'd7;
        @(posedge clk); #2;
        repeat (9) begin @(posedge clk); #2; end
        flush_in = 1;
        @(posedge clk); #2;
        flush_in = 0; mul_div_op_in = 4'hF;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_out) extra++;
            if (i == 0) check("flush_no_stall", {31'd0, stall_out}, 32'd0);
        end
        check("flush_no_done", extra, 0);
        check("flush_result_held", result_out, prev);

        // Reset mid-divide.
        @(posedge clk); #2;
        mul_div_op_in = 4'd5; rs1_in = 32'd100; rs2_in = 32'd7;
        @(posedge clk); #2;
        repeat (9) begin @(posedge clk); #2; end
        reset = 1;
        @(negedge clk);
        check("rst_mid_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #2;
        @(negedge clk);
        check("rst_mid_result", result_out, 32'd0);
        check("rst_mid_done", {31'd0, done_out}, 32'd0);
        @(posedge clk); #2;
        reset = 0; mul_div_op_in = 4'hF;
        repeat (3) begin @(posedge clk); #2; end

        // Flush in IDLE blocks the start.
        mul_div_op_in = 4'd4; rs1_in = 32'd50; rs2_in = 32'd5; flush_in = 1;
        @(negedge clk);
        check("idle_flush_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #2;
        flush_in = 0;
        send(4'd4, 32'd50, 32'd5, st, dn, rs);
        check("after_flush_div", rs, 32'd10);

        for (int n = 0; n < 70; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = pick();
            b  = pick();
            send(op, a, b, st, dn, rs);
            if (op <= 4'd7) check("rand_result", rs, ref_result(op, a, b));
        end
        mul_div_op_in = 4'hF;
        repeat (3) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
